// File: rtl/output_accum_unit.sv
// Read-modify-write accumulator in front of an output memory write-back port.
// Adds PE partial sums to stored values lane-wise with signed saturation, forwarding in-flight results.
module output_accum_unit #(
  parameter int unsigned LANES    = 32,
  parameter int unsigned LANE_W   = 16,
  parameter int unsigned DATA_W   = LANES * LANE_W,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pe_valid_in,
  input  logic [ADDR_W-1:0] pe_addr_in,
  input  logic [DATA_W-1:0] pe_data_in,
  input  logic              pe_clear_in,
  output logic              rd_valid_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              wr_valid_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              sat_flag_out,
  input  logic              sat_clr_in,
  output logic              idle_out
);

  localparam int unsigned HIST = READ_LAT + 1;

  // Delay line covering the memory read latency.
  logic              dl_valid_q [READ_LAT];
  logic [ADDR_W-1:0] dl_addr_q  [READ_LAT];
  logic [DATA_W-1:0] dl_data_q  [READ_LAT];
  logic              dl_clear_q [READ_LAT];

  // Result history; entry 0 is the write-back register, entry i is distance i+1.
  logic              hist_valid_q [HIST];
  logic [ADDR_W-1:0] hist_addr_q  [HIST];
  logic [DATA_W-1:0] hist_data_q  [HIST];

  logic              sat_q;

  logic              sa_valid;
  logic [ADDR_W-1:0] sa_addr;
  logic [DATA_W-1:0] sa_data;
  logic              sa_clear;

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] sum;
  logic [LANES-1:0]  lane_sat;
  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b;
  logic [LANE_W:0]   lane_wide;
  logic              sat_event;

  assign rd_valid_out = pe_valid_in & ~pe_clear_in & ~reset;
  assign rd_addr_out  = pe_addr_in;

  assign sa_valid = dl_valid_q[READ_LAT-1];
  assign sa_addr  = dl_addr_q[READ_LAT-1];
  assign sa_data  = dl_data_q[READ_LAT-1];
  assign sa_clear = dl_clear_q[READ_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(READ_LAT); i++) begin
        dl_valid_q[i] <= 1'b0;
        dl_addr_q[i]  <= '0;
        dl_data_q[i]  <= '0;
        dl_clear_q[i] <= 1'b0;
      end
    end else begin
      dl_valid_q[0] <= pe_valid_in;
      dl_addr_q[0]  <= pe_addr_in;
      dl_data_q[0]  <= pe_data_in;
      dl_clear_q[0] <= pe_clear_in;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_addr_q[i]  <= dl_addr_q[i-1];
        dl_data_q[i]  <= dl_data_q[i-1];
        dl_clear_q[i] <= dl_clear_q[i-1];
      end
    end
  end

  // Scan oldest to newest so the nearest matching result wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = int'(HIST) - 1; i >= 0; i--) begin
      if (hist_valid_q[i] && (hist_addr_q[i] == sa_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = hist_data_q[i];
      end
    end
    if (sa_clear) begin
      opnd_b = '0;
    end else if (fwd_hit) begin
      opnd_b = fwd_data;
    end else begin
      opnd_b = rd_data_in;
    end
  end

  always_comb begin
    sum       = '0;
    lane_sat  = '0;
    lane_a    = '0;
    lane_b    = '0;
    lane_wide = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_a    = sa_data[l*LANE_W +: LANE_W];
      lane_b    = opnd_b[l*LANE_W +: LANE_W];
      lane_wide = {lane_a[LANE_W-1], lane_a} + {lane_b[LANE_W-1], lane_b};
      // Sign bits disagree only on overflow; the carry-out bit gives the true sign.
      if (lane_wide[LANE_W] != lane_wide[LANE_W-1]) begin
        lane_sat[l] = 1'b1;
        sum[l*LANE_W +: LANE_W] = lane_wide[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                    : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
        sum[l*LANE_W +: LANE_W] = lane_wide[LANE_W-1:0];
      end
    end
  end

  assign sat_event = sa_valid & (|lane_sat);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(HIST); i++) begin
        hist_valid_q[i] <= 1'b0;
        hist_addr_q[i]  <= '0;
        hist_data_q[i]  <= '0;
      end
      sat_q <= 1'b0;
    end else begin
      hist_valid_q[0] <= sa_valid;
      hist_addr_q[0]  <= sa_addr;
      hist_data_q[0]  <= sum;
      for (int i = 1; i < int'(HIST); i++) begin
        hist_valid_q[i] <= hist_valid_q[i-1];
        hist_addr_q[i]  <= hist_addr_q[i-1];
        hist_data_q[i]  <= hist_data_q[i-1];
      end
      if (sat_event) begin
        sat_q <= 1'b1;
      end else if (sat_clr_in) begin
        sat_q <= 1'b0;
      end
    end
  end

  always_comb begin
    idle_out = ~pe_valid_in & ~hist_valid_q[0];
    for (int i = 0; i < int'(READ_LAT); i++) begin
      idle_out = idle_out & ~dl_valid_q[i];
    end
  end

  assign wr_valid_out = hist_valid_q[0];
  assign wr_addr_out  = hist_addr_q[0];
  assign wr_data_out  = hist_data_q[0];
  assign sat_flag_out = sat_q;

endmodule

// File: tb/tb_output_accum_unit.sv
// Bench for output_accum_unit: memory model plus a sequential-accumulation reference model.
module tb_output_accum_unit;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pe_valid_in = 1'b0;
  logic [7:0]   pe_addr_in = '0;
  logic [511:0] pe_data_in = '0;
  logic         pe_clear_in = 1'b0;
  logic         rd_valid_out;
  logic [7:0]   rd_addr_out;
  logic [511:0] rd_data_in = '0;
  logic         wr_valid_out;
  logic [7:0]   wr_addr_out;
  logic [511:0] wr_data_out;
  logic         sat_flag_out;
  logic         sat_clr_in = 1'b0;
  logic         idle_out;

  output_accum_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pe_valid_in  (pe_valid_in),
    .pe_addr_in   (pe_addr_in),
    .pe_data_in   (pe_data_in),
    .pe_clear_in  (pe_clear_in),
    .rd_valid_out (rd_valid_out),
    .rd_addr_out  (rd_addr_out),
    .rd_data_in   (rd_data_in),
    .wr_valid_out (wr_valid_out),
    .wr_addr_out  (wr_addr_out),
    .wr_data_out  (wr_data_out),
    .sat_flag_out (sat_flag_out),
    .sat_clr_in   (sat_clr_in),
    .idle_out     (idle_out)
  );

  always #5 clk = ~clk;

  // Memory: a read returns pre-write contents; unrequested cycles return junk.
  logic [511:0] mem [256];
  logic         pre_en = 1'b0;
  logic [7:0]   pre_addr = '0;
  logic [511:0] pre_data = '0;

  always @(posedge clk) begin
    if (rd_valid_out) begin
      rd_data_in <= mem[rd_addr_out];
    end else begin
      for (int k = 0; k < 16; k++) rd_data_in[k*32 +: 32] <= $urandom;
    end
    if (wr_valid_out) mem[wr_addr_out] <= wr_data_out;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  typedef struct {
    int           due;
    logic [7:0]   addr;
    logic [511:0] data;
  } wr_t;

  wr_t          q[$];
  logic [511:0] ref_mem [256];
  bit           sat_ref = 1'b0;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [511:0] rep(input logic [15:0] x);
    return {32{x}};
  endfunction

  function automatic logic [511:0] sat_add(input logic [511:0] a, input logic [511:0] b,
                                           output bit sat);
    logic [511:0] r;
    int           s;
    r   = '0;
    sat = 1'b0;
    for (int l = 0; l < 32; l++) begin
      s = int'($signed(a[l*16 +: 16])) + int'($signed(b[l*16 +: 16]));
      if (s > 32767) begin
        s   = 32767;
        sat = 1'b1;
      end else if (s < -32768) begin
        s   = -32768;
        sat = 1'b1;
      end
      r[l*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [511:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // One cycle: check registered outputs, drive inputs, check combinational outputs, update model.
  task automatic do_cycle(input bit v, input logic [7:0] a, input logic [511:0] d, input bit c,
                          input bit rst = 1'b0);
    bit           inflight;
    bit           exp_w;
    bit           sat;
    logic [511:0] res;
    @(negedge clk);
    cyc++;
    inflight = q.size() > 0;
    exp_w    = inflight && (q[0].due == cyc);
    check("wr_valid", wr_valid_out, exp_w);
    if (exp_w) begin
      check("wr_addr", wr_addr_out, q[0].addr);
      check("wr_data", wr_data_out, q[0].data);
      void'(q.pop_front());
    end
    reset       = rst;
    pe_valid_in = v;
    pe_addr_in  = a;
    pe_data_in  = d;
    pe_clear_in = c;
    #1;
    if (rst) begin
      q.delete();
      sat_ref = 1'b0;
    end else begin
      check("rd_valid", rd_valid_out, v & ~c);
      if (v && !c) check("rd_addr", rd_addr_out, a);
      check("idle", idle_out, !v && !inflight);
      if (v) begin
        res        = sat_add(d, c ? 512'd0 : ref_mem[a], sat);
        ref_mem[a] = res;
        sat_ref    = sat_ref | sat;
        q.push_back('{due: cyc + 2, addr: a, data: res});
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 8'd0, 512'd0, 1'b0);
  endtask

  initial begin
    logic [511:0] v0;
    logic [511:0] v1;
    logic [511:0] saved;
    logic [511:0] rd;
    logic [7:0]   addrs [5];
    logic [7:0]   a;
    bit           v;
    bit           c;

    repeat (2) @(posedge clk);
    do_cycle(1'b0, 8'd0, 512'd0, 1'b0, 1'b1);
    check("reset_idle", idle_out, 1'b1);
    check("reset_sat", sat_flag_out, 1'b0);
    check("reset_wr_addr", wr_addr_out, 8'd0);
    check("reset_wr_data", wr_data_out, 512'd0);
    idle_cycles(1);

    // Single packet onto a stored value.
    preload(8'd5, rep(16'd10));
    do_cycle(1'b1, 8'd5, rep(16'd3), 1'b0);
    idle_cycles(4);
    check("single_mem5", mem[5], rep(16'd13));

    // Back-to-back same address.
    preload(8'd7, 512'd0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'd7, rep(16'd1), 1'b0);
    idle_cycles(4);
    check("b2b_mem7", mem[7], rep(16'd4));

    // Distance 2 (forwarded) and distance 3 (memory).
    preload(8'd9, 512'd0);
    do_cycle(1'b1, 8'd9, rep(16'd5), 1'b0);
    idle_cycles(1);
    do_cycle(1'b1, 8'd9, rep(16'd5), 1'b0);
    idle_cycles(4);
    check("dist2_mem9", mem[9], rep(16'd10));
    preload(8'd9, 512'd0);
    do_cycle(1'b1, 8'd9, rep(16'd5), 1'b0);
    idle_cycles(2);
    do_cycle(1'b1, 8'd9, rep(16'd5), 1'b0);
    idle_cycles(4);
    check("dist3_mem9", mem[9], rep(16'd10));

    // Saturation and sticky flag clear.
    v0 = 512'd0;
    v0[15:0] = 16'd32000;
    preload(8'd1, v0);
    v1 = 512'd0;
    v1[15:0]  = 16'd1000;
    v1[31:16] = 16'hfffb;
    do_cycle(1'b1, 8'd1, v1, 1'b0);
    idle_cycles(4);
    v0 = 512'd0;
    v0[15:0]  = 16'h7fff;
    v0[31:16] = 16'hfffb;
    check("sat_mem1", mem[1], v0);
    check("sat_flag_set", sat_flag_out, 1'b1);
    sat_clr_in = 1'b1;
    idle_cycles(1);
    sat_clr_in = 1'b0;
    sat_ref    = 1'b0;
    check("sat_flag_clr", sat_flag_out, 1'b0);

    // Clear then accumulate.
    preload(8'd2, rep(16'd100));
    do_cycle(1'b1, 8'd2, rep(16'd4), 1'b1);
    do_cycle(1'b1, 8'd2, rep(16'd4), 1'b0);
    idle_cycles(4);
    check("clear_mem2", mem[2], rep(16'd8));

    // Reset in the cycle after accepting a packet.
    preload(8'd20, rep(16'd50));
    saved = ref_mem[20];
    do_cycle(1'b1, 8'd20, rep(16'd7), 1'b0);
    do_cycle(1'b0, 8'd0, 512'd0, 1'b0, 1'b1);
    ref_mem[20] = saved;
    idle_cycles(4);
    check("rst_mem20", mem[20], rep(16'd50));

    // Randomized traffic on a small address set to provoke hazards.
    addrs[0] = 8'd0;
    addrs[1] = 8'd1;
    addrs[2] = 8'd2;
    addrs[3] = 8'd3;
    addrs[4] = 8'd255;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 16; k++) rd[k*32 +: 32] = $urandom;
      preload(addrs[i], rd);
    end
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0);
      a = addrs[$urandom_range(0, 4)];
      for (int k = 0; k < 16; k++) rd[k*32 +: 32] = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        for (int l = 0; l < 32; l++) rd[l*16 +: 16] = 16'($signed($urandom_range(0, 200)) - 100);
      end
      do_cycle(v, a, rd, c);
    end
    idle_cycles(4);
    for (int i = 0; i < 5; i++) check("rand_mem", mem[addrs[i]], ref_mem[addrs[i]]);
    check("rand_sat", sat_flag_out, sat_ref);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
